// File: rtl/jpc_fetch_if.sv
// jpc_fetch_if: the fetch stage's two handshakes bundled together.
//   Instruction-memory read channel:
//     imem_req_O, imem_addr_O    request strobe and address (fetch -> memory)
//     imem_rvalid_I, imem_rdata_I  read response (memory -> fetch)
//   Decode channel:
//     instr_valid_O, instr_O, instr_pc_O   fetched word and its PC (fetch -> decode)
//     instr_ready_I                        decode accepts this cycle (decode -> fetch)
// The master modport is the fetch stage. The slave modport is the memory/decode side.
interface jpc_fetch_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  imem_req_O;
  logic [ADDR_WIDTH-1:0] imem_addr_O;
  logic                  imem_rvalid_I;
  logic [DATA_WIDTH-1:0] imem_rdata_I;
  logic                  instr_valid_O;
  logic [DATA_WIDTH-1:0] instr_O;
  logic [ADDR_WIDTH-1:0] instr_pc_O;
  logic                  instr_ready_I;

  modport master (
    output imem_req_O, imem_addr_O, instr_valid_O, instr_O, instr_pc_O,
    input  imem_rvalid_I, imem_rdata_I, instr_ready_I
  );

  modport slave (
    input  imem_req_O, imem_addr_O, instr_valid_O, instr_O, instr_pc_O,
    output imem_rvalid_I, imem_rdata_I, instr_ready_I
  );
endinterface

// File: rtl/jpc_fetch.sv
// jpc_fetch: instruction fetch stage located after the PC register.
// It issues one memory read per PC value and allows one outstanding request.
// It hands each fetched word to decode over a valid/ready handshake.
// It also drives next_pc_O/pc_enable_O, which advance the PC register by +4
// or move it to a redirect target from execute.
// Ports:
//   clk, rst       clock; synchronous active-high reset
//   pc_I           current PC (from the PC register)
//   next_pc_O      next PC value (combinational)
//   pc_enable_O    PC update strobe (combinational)
//   redirect_I     taken branch/jump pulse; redirect_pc_I is its target
//   bus            memory read channel + decode channel (master side)
`ifndef JPC_ADDRESS_WIDTH
`define JPC_ADDRESS_WIDTH 32
`endif

module jpc_fetch #(
  parameter int unsigned ADDR_WIDTH = `JPC_ADDRESS_WIDTH,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] pc_I,
  output logic [ADDR_WIDTH-1:0] next_pc_O,
  output logic                  pc_enable_O,
  input  logic                  redirect_I,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_I,
  jpc_fetch_if.master           bus
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DRAIN} state_t;

  localparam logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);

  state_t                state_q, state_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [ADDR_WIDTH-1:0] instr_pc_q, instr_pc_d;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
  logic [ADDR_WIDTH-1:0] skid_pc_q, skid_pc_d;

  logic out_free;
  logic deliver;
  logic from_skid;
  logic req;

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    instr_d     = instr_q;
    instr_pc_d  = instr_pc_q;
    skid_data_d = skid_data_q;
    skid_pc_d   = skid_pc_q;
    deliver     = 1'b0;
    from_skid   = 1'b0;
    req         = 1'b0;
    out_free    = !valid_q || bus.instr_ready_I;

    case (state_q)
      S_REQ: begin
        if (!redirect_I) begin
          req     = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_I) begin
          // If the response has not arrived yet, it is still in flight. Drain it before issuing a new request.
          state_d = bus.imem_rvalid_I ? S_REQ : S_DRAIN;
        end else if (bus.imem_rvalid_I) begin
          if (out_free) begin
            deliver = 1'b1;
            state_d = S_REQ;
          end else begin
            skid_data_d = bus.imem_rdata_I;
            skid_pc_d   = pc_I;
            state_d     = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (redirect_I) begin
          state_d = S_REQ;
        end else if (out_free) begin
          deliver   = 1'b1;
          from_skid = 1'b1;
          state_d   = S_REQ;
        end
      end
      S_DRAIN: begin
        // A redirect here only retargets the PC. The stale response must still be absorbed.
        if (bus.imem_rvalid_I) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase

    if (redirect_I) begin
      valid_d     = 1'b0;
      skid_data_d = '0;
      skid_pc_d   = '0;
    end else if (deliver) begin
      valid_d    = 1'b1;
      instr_d    = from_skid ? skid_data_q : bus.imem_rdata_I;
      instr_pc_d = from_skid ? skid_pc_q   : pc_I;
    end else if (valid_q && bus.instr_ready_I) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_REQ;
      valid_q     <= 1'b0;
      instr_q     <= '0;
      instr_pc_q  <= '0;
      skid_data_q <= '0;
      skid_pc_q   <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      instr_q     <= instr_d;
      instr_pc_q  <= instr_pc_d;
      skid_data_q <= skid_data_d;
      skid_pc_q   <= skid_pc_d;
    end
  end

  always_comb begin
    next_pc_O   = '0;
    pc_enable_O = 1'b0;
    if (!rst) begin
      next_pc_O   = redirect_I ? (redirect_pc_I & ALIGN_MASK) : (pc_I + PC_STEP);
      pc_enable_O = redirect_I || deliver;
    end
  end

  assign bus.imem_req_O    = req && !rst;
  assign bus.imem_addr_O   = pc_I;
  assign bus.instr_valid_O = valid_q;
  assign bus.instr_O       = instr_q;
  assign bus.instr_pc_O    = instr_pc_q;

endmodule

// File: tb/tb_jpc_fetch.sv
// Bench for jpc_fetch. It models the PC register and a latency-programmable
// instruction memory. Delivered instructions are checked against a
// scoreboard queue, and per-cycle output checks follow hand-written sequences.
module tb_jpc_fetch;

  logic        clk;
  logic        rst;
  logic [31:0] pc_reg;
  logic [31:0] next_pc;
  logic        pc_en;
  logic        redirect_I;
  logic [31:0] redirect_pc_I;

  jpc_fetch_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  jpc_fetch #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_I         (pc_reg),
    .next_pc_O    (next_pc),
    .pc_enable_O  (pc_en),
    .redirect_I   (redirect_I),
    .redirect_pc_I(redirect_pc_I),
    .bus          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [31:0] pc;
    logic        redir;
    logic [31:0] tgt;
    logic [31:0] exp_next;
    logic        exp_en;
    logic        exp_req;
  } vec_t;
  vec_t tbl[8];

  int n_cmp = 0;
  int n_bad = 0;

  // memory / reference state
  logic        mem_pending = 1'b0;
  logic [31:0] mem_addr = '0;
  int          mem_cnt = 0;
  int          lat_fix = 1;
  logic        stale = 1'b0;
  logic [31:0] exp_fetch = '0;

  // values sampled each cycle
  logic        s_req, s_en, s_valid;
  logic [31:0] s_addr, s_next, s_instr, s_ipc, s_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ((a >> 2) + 32'd1) * 32'h11;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_cycle(input logic r, input logic redir, input logic [31:0] tgt,
                           input logic rdy, input logic ovr_en, input logic [31:0] ovr,
                           input logic stray);
    logic        rv;
    logic        upd_en;
    logic        upd_rst;
    logic [31:0] upd_next;
    exp_t        e;
    @(negedge clk);
    rst           = r;
    redirect_I    = redir;
    redirect_pc_I = tgt;
    bus.instr_ready_I = rdy;
    if (ovr_en) pc_reg = ovr;
    rv = 1'b0;
    if (mem_pending) begin
      mem_cnt--;
      if (mem_cnt == 0) rv = 1'b1;
    end
    bus.imem_rvalid_I = rv || stray;
    bus.imem_rdata_I  = (rv || stray) ? mem_word(mem_addr) : 32'h0;
    #1;
    s_req   = bus.imem_req_O;
    s_addr  = bus.imem_addr_O;
    s_en    = pc_en;
    s_next  = next_pc;
    s_valid = bus.instr_valid_O;
    s_instr = bus.instr_O;
    s_ipc   = bus.instr_pc_O;
    s_pc    = pc_reg;
    if (r) begin
      chk("rst_pc_enable", {31'b0, s_en}, 32'h0);
      chk("rst_next_pc", s_next, 32'h0);
      chk("rst_req", {31'b0, s_req}, 32'h0);
      sb.delete();
      mem_pending = 1'b0;
      stale       = 1'b0;
      exp_fetch   = 32'h0;
    end else begin
      if (s_valid && rdy) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_instr_pc", s_ipc, 32'hxxxxxxxx);
        end else begin
          e = sb.pop_front();
          chk("sb_instr", s_instr, e.data);
          chk("sb_instr_pc", s_ipc, e.pc);
        end
      end
      if (rv) begin
        mem_pending = 1'b0;
        if (!stale && !redir) begin
          sb.push_back('{pc: exp_fetch, data: mem_word(exp_fetch)});
          exp_fetch = exp_fetch + 32'd4;
        end
        stale = 1'b0;
      end
      if (redir) begin
        chk("redir_pc_enable", {31'b0, s_en}, 32'h1);
        chk("redir_next_pc", s_next, tgt & 32'hFFFF_FFFC);
        sb.delete();
        if (mem_pending) stale = 1'b1;
        exp_fetch = tgt & 32'hFFFF_FFFC;
      end else if (s_en) begin
        chk("seq_next_pc", s_next, s_pc + 32'd4);
      end
      if (s_req) begin
        chk("req_addr", s_addr, exp_fetch);
        chk("one_outstanding", {31'b0, mem_pending}, 32'h0);
        mem_pending = 1'b1;
        mem_addr    = s_addr;
        mem_cnt     = (lat_fix > 0) ? lat_fix : int'($urandom_range(1, 3));
      end
    end
    upd_en   = s_en;
    upd_next = s_next;
    upd_rst  = r;
    @(posedge clk);
    #1;
    if (upd_rst) pc_reg = 32'h0;
    else if (upd_en) pc_reg = upd_next;
  endtask

  task automatic rc(input logic r, input logic redir, input logic [31:0] tgt, input logic rdy);
    run_cycle(r, redir, tgt, rdy, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic do_reset();
    rc(1'b1, 1'b0, 32'h0, 1'b1);
    rc(1'b1, 1'b0, 32'h0, 1'b1);
    chk("reset_valid", {31'b0, s_valid}, 32'h0);
    chk("reset_instr", s_instr, 32'h0);
    chk("reset_instr_pc", s_ipc, 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    redirect_I = 1'b0;
    redirect_pc_I = 32'h0;
    pc_reg = 32'h0;
    bus.imem_rvalid_I = 1'b0;
    bus.imem_rdata_I  = 32'h0;
    bus.instr_ready_I = 1'b1;

    tbl[0] = '{pc: 32'h0000_1000, redir: 1'b0, tgt: 32'h0,         exp_next: 32'h0000_1004, exp_en: 1'b0, exp_req: 1'b0};
    tbl[1] = '{pc: 32'hFFFF_FFFC, redir: 1'b0, tgt: 32'h0,         exp_next: 32'h0000_0000, exp_en: 1'b0, exp_req: 1'b0};
    tbl[2] = '{pc: 32'h7FFF_FFFC, redir: 1'b0, tgt: 32'h0,         exp_next: 32'h8000_0000, exp_en: 1'b0, exp_req: 1'b0};
    tbl[3] = '{pc: 32'h0000_0020, redir: 1'b1, tgt: 32'h0000_0123, exp_next: 32'h0000_0120, exp_en: 1'b1, exp_req: 1'b0};
    tbl[4] = '{pc: 32'h0000_0020, redir: 1'b1, tgt: 32'hFFFF_FFFF, exp_next: 32'hFFFF_FFFC, exp_en: 1'b1, exp_req: 1'b0};
    tbl[5] = '{pc: 32'h0000_0000, redir: 1'b0, tgt: 32'h0,         exp_next: 32'h0000_0004, exp_en: 1'b0, exp_req: 1'b0};
    tbl[6] = '{pc: 32'h0000_0055, redir: 1'b1, tgt: 32'h0000_0002, exp_next: 32'h0000_0000, exp_en: 1'b1, exp_req: 1'b0};
    tbl[7] = '{pc: 32'h0000_0008, redir: 1'b1, tgt: 32'h0000_0040, exp_next: 32'h0000_0040, exp_en: 1'b1, exp_req: 1'b0};

    // zero-wait memory, decode always ready
    lat_fix = 1;
    do_reset();
    rc(0, 0, 0, 1); chk("s1_req0", {31'b0, s_req}, 32'h1); chk("s1_addr0", s_addr, 32'h0);
    rc(0, 0, 0, 1); chk("s1_noreq1", {31'b0, s_req}, 32'h0); chk("s1_en1", {31'b0, s_en}, 32'h1);
                    chk("s1_next1", s_next, 32'h4);
    rc(0, 0, 0, 1); chk("s1_addr2", s_addr, 32'h4); chk("s1_req2", {31'b0, s_req}, 32'h1);
                    chk("s1_valid2", {31'b0, s_valid}, 32'h1); chk("s1_instr2", s_instr, 32'h11);
                    chk("s1_ipc2", s_ipc, 32'h0);
    rc(0, 0, 0, 1);
    rc(0, 0, 0, 1); chk("s1_addr4", s_addr, 32'h8); chk("s1_instr4", s_instr, 32'h22);
                    chk("s1_ipc4", s_ipc, 32'h4);
    rc(0, 0, 0, 1);
    rc(0, 0, 0, 1); chk("s1_instr6", s_instr, 32'h33); chk("s1_ipc6", s_ipc, 32'h8);

    // decode stalls: second word parks in the skid register
    do_reset();
    rc(0, 0, 0, 1);
    rc(0, 0, 0, 1);
    rc(0, 0, 0, 0); chk("s2_instr2", s_instr, 32'h11); chk("s2_req2", {31'b0, s_req}, 32'h1);
    rc(0, 0, 0, 0); chk("s2_en_busy", {31'b0, s_en}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      rc(0, 0, 0, 0);
      chk("s2_hold_noreq", {31'b0, s_req}, 32'h0);
      chk("s2_hold_pc", s_pc, 32'h4);
      chk("s2_hold_instr", s_instr, 32'h11);
    end
    rc(0, 0, 0, 1); chk("s2_skid_en", {31'b0, s_en}, 32'h1); chk("s2_skid_next", s_next, 32'h8);
    rc(0, 0, 0, 1); chk("s2_valid", {31'b0, s_valid}, 32'h1); chk("s2_instr", s_instr, 32'h22);
                    chk("s2_ipc", s_ipc, 32'h4); chk("s2_resume_addr", s_addr, 32'h8);
                    chk("s2_resume_req", {31'b0, s_req}, 32'h1);

    // redirect while waiting; stale response arrives 3 cycles later
    lat_fix = 4;
    do_reset();
    rc(0, 0, 0, 1); chk("s3_req0", {31'b0, s_req}, 32'h1);
    rc(0, 1, 32'h103, 1); chk("s3_next", s_next, 32'h100); chk("s3_en", {31'b0, s_en}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      rc(0, 0, 0, 1);
      chk("s3_drain_noreq", {31'b0, s_req}, 32'h0);
      chk("s3_drain_valid", {31'b0, s_valid}, 32'h0);
    end
    rc(0, 0, 0, 1); chk("s3_req_tgt", {31'b0, s_req}, 32'h1); chk("s3_addr_tgt", s_addr, 32'h100);
                    chk("s3_valid_after", {31'b0, s_valid}, 32'h0);

    // redirect coincides with a deliverable response
    lat_fix = 1;
    do_reset();
    rc(0, 0, 0, 1);
    rc(0, 0, 0, 1);
    rc(0, 0, 0, 1);
    rc(0, 1, 32'h200, 1); chk("s4_en", {31'b0, s_en}, 32'h1); chk("s4_next", s_next, 32'h200);
    rc(0, 0, 0, 1); chk("s4_valid", {31'b0, s_valid}, 32'h0); chk("s4_req", {31'b0, s_req}, 32'h1);
                    chk("s4_addr", s_addr, 32'h200);

    // PC wrap at the top of the address space
    do_reset();
    rc(0, 1, 32'hFFFF_FFFC, 1); chk("s5_req_suppr", {31'b0, s_req}, 32'h0);
    rc(0, 0, 0, 1); chk("s5_addr_top", s_addr, 32'hFFFF_FFFC);
    rc(0, 0, 0, 1); chk("s5_en", {31'b0, s_en}, 32'h1); chk("s5_wrap_next", s_next, 32'h0);
    rc(0, 0, 0, 1); chk("s5_addr_wrap", s_addr, 32'h0); chk("s5_ipc", s_ipc, 32'hFFFF_FFFC);
                    chk("s5_instr", s_instr, mem_word(32'hFFFF_FFFC));

    // reset during a pending fetch; a late response must be ignored
    lat_fix = 3;
    do_reset();
    rc(0, 0, 0, 1);
    rc(1, 0, 0, 1);
    rc(1, 0, 0, 1); chk("s6_valid", {31'b0, s_valid}, 32'h0); chk("s6_instr", s_instr, 32'h0);
                    chk("s6_ipc", s_ipc, 32'h0);
    run_cycle(0, 0, 0, 1, 0, 0, 1);
    chk("s6_req", {31'b0, s_req}, 32'h1); chk("s6_addr", s_addr, 32'h0);
    chk("s6_stray_en", {31'b0, s_en}, 32'h0);
    rc(0, 0, 0, 1); chk("s6_stray_valid", {31'b0, s_valid}, 32'h0);
    for (int i = 0; i < 6; i++) rc(0, 0, 0, 1);

    // next-PC vectors applied while draining (no deliver possible)
    lat_fix = 30;
    do_reset();
    rc(0, 0, 0, 1);
    rc(0, 1, 32'h40, 1);
    for (int i = 0; i < 8; i++) begin
      run_cycle(0, tbl[i].redir, tbl[i].tgt, 1, 1, tbl[i].pc, 0);
      chk("tbl_next_pc", s_next, tbl[i].exp_next);
      chk("tbl_pc_enable", {31'b0, s_en}, {31'b0, tbl[i].exp_en});
      chk("tbl_req", {31'b0, s_req}, {31'b0, tbl[i].exp_req});
    end
    lat_fix = 1;
    for (int i = 0; i < 30; i++) rc(0, 0, 0, 1);

    // randomised traffic, scoreboard only
    lat_fix = 0;
    for (int i = 0; i < 600; i++) begin
      logic        r_rst, r_red, r_rdy;
      logic [31:0] r_tgt;
      r_rst = ($urandom_range(0, 149) == 0);
      r_red = !r_rst && ($urandom_range(0, 11) == 0);
      r_rdy = ($urandom_range(0, 3) != 0);
      r_tgt = $urandom;
      rc(r_rst, r_red, r_tgt, r_rdy);
    end
    for (int i = 0; i < 10; i++) rc(0, 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
